// File: rtl/pipe_ctrl_unit.sv
// ID-stage control for the 5-stage MIPS-subset pipeline: decode, ID/EX control register,
// load-use stall and flush bubbles. Define PIPE_CTRL_JUMP_EN to decode j/jal.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           instr_i,
  input  logic                  valid_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic                  regwrite_o,
  output logic                  alusrc_o,
  output logic                  regdst_o,
  output logic                  branch_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic                  memtoreg_o,
  output logic                  jump_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [1:0]            branch_type_o,
  output logic [REG_ADDR_W-1:0] wr_reg_o,
  output logic                  illegal_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BGE  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef PIPE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  alusrc;
    logic                  regdst;
    logic                  branch;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic                  jump;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [1:0]            branch_type;
    logic [REG_ADDR_W-1:0] wr_reg;
  } ctrl_t;

  logic [5:0]            opcode_s;
  logic [REG_ADDR_W-1:0] rs_s;
  logic [REG_ADDR_W-1:0] rt_s;
  logic [REG_ADDR_W-1:0] rd_s;
  logic                  known_s;
  logic                  uses_rt_s;
  logic                  jal_s;
  logic                  stall_s;
  logic                  illegal_set_s;
  ctrl_t                 dec_s;
  ctrl_t                 idex_nxt_s;
  ctrl_t                 idex_r;
  logic                  illegal_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic                  unused_bits_s;

  assign opcode_s = instr_i[31:26];
  assign rs_s     = instr_i[21 +: REG_ADDR_W];
  assign rt_s     = instr_i[16 +: REG_ADDR_W];
  assign rd_s     = instr_i[11 +: REG_ADDR_W];

  // Opcode decode into a full control bundle; unknown opcodes leave everything zero.
  always_comb begin
    dec_s     = '0;
    known_s   = 1'b0;
    uses_rt_s = 1'b0;
    jal_s     = 1'b0;
    case (opcode_s)
      OP_R: begin
        known_s = 1'b1; uses_rt_s = 1'b1;
        dec_s.regdst = 1'b1; dec_s.regwrite = 1'b1;
        dec_s.alu_op[1] = 1'b1; dec_s.branch_type = 2'b11;
      end
      OP_BEQ, OP_BNE, OP_BGT, OP_BGE: begin
        known_s = 1'b1; uses_rt_s = 1'b1;
        dec_s.branch = 1'b1; dec_s.alu_op[0] = 1'b1;
        case (opcode_s)
          OP_BEQ:  dec_s.branch_type = 2'b00;
          OP_BGT:  dec_s.branch_type = 2'b01;
          OP_BGE:  dec_s.branch_type = 2'b10;
          default: dec_s.branch_type = 2'b11;
        endcase
      end
      OP_ADDI: begin
        known_s = 1'b1;
        dec_s.alusrc = 1'b1; dec_s.regwrite = 1'b1; dec_s.branch_type = 2'b11;
      end
      OP_SLTI: begin
        known_s = 1'b1;
        dec_s.alusrc = 1'b1; dec_s.regwrite = 1'b1;
        dec_s.alu_op[2] = 1'b1; dec_s.branch_type = 2'b11;
      end
      OP_LW: begin
        known_s = 1'b1;
        dec_s.alusrc = 1'b1; dec_s.regwrite = 1'b1; dec_s.memread = 1'b1;
        dec_s.memtoreg = 1'b1; dec_s.branch_type = 2'b11;
      end
      OP_SW: begin
        known_s = 1'b1; uses_rt_s = 1'b1;
        dec_s.alusrc = 1'b1; dec_s.memwrite = 1'b1; dec_s.branch_type = 2'b11;
      end
`ifdef PIPE_CTRL_JUMP_EN
      OP_J: begin
        known_s = 1'b1;
        dec_s.jump = 1'b1; dec_s.branch_type = 2'b11;
      end
      OP_JAL: begin
        known_s = 1'b1; jal_s = 1'b1;
        dec_s.jump = 1'b1; dec_s.regwrite = 1'b1; dec_s.branch_type = 2'b11;
      end
`endif
      default: begin
        known_s = 1'b0;
      end
    endcase
    dec_s.valid = known_s;
    // jal links into the top register; non-writers carry register 0 so they never match a hazard
    if (!dec_s.regwrite) begin
      dec_s.wr_reg = '0;
    end else if (jal_s) begin
      dec_s.wr_reg = {REG_ADDR_W{1'b1}};
    end else if (dec_s.regdst) begin
      dec_s.wr_reg = rd_s;
    end else begin
      dec_s.wr_reg = rt_s;
    end
  end

  assign stall_s = valid_i & idex_r.valid & idex_r.memread & (idex_r.wr_reg != '0) &
                   ((idex_r.wr_reg == rs_s) | ((idex_r.wr_reg == rt_s) & uses_rt_s)) &
                   ~branch_taken_i;

  // Wrong-path (flushed) opcodes are not reported as illegal.
  assign illegal_set_s = valid_i & ~known_s & ~branch_taken_i & ~stall_s;

  // ID/EX load selection: flush, then stall, then empty slot, then decoded instruction.
  always_comb begin
    idex_nxt_s = '0;
    if (branch_taken_i) begin
      idex_nxt_s = '0;
    end else if (stall_s) begin
      idex_nxt_s = '0;
    end else if (!valid_i) begin
      idex_nxt_s = '0;
    end else if (!known_s) begin
      idex_nxt_s = '0;
    end else begin
      idex_nxt_s = dec_s;
    end
  end

  // ID/EX register, sticky illegal flag and saturating stall counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_r      <= '0;
      illegal_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      idex_r <= idex_nxt_s;
      if (illegal_set_s) begin
        illegal_r <= 1'b1;
      end
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_o       = stall_s;
  assign valid_o       = idex_r.valid;
  assign regwrite_o    = idex_r.regwrite;
  assign alusrc_o      = idex_r.alusrc;
  assign regdst_o      = idex_r.regdst;
  assign branch_o      = idex_r.branch;
  assign memread_o     = idex_r.memread;
  assign memwrite_o    = idex_r.memwrite;
  assign memtoreg_o    = idex_r.memtoreg;
  assign alu_op_o      = idex_r.alu_op;
  assign branch_type_o = idex_r.branch_type;
  assign wr_reg_o      = idex_r.wr_reg;
  assign illegal_o     = illegal_r;
  assign stall_cnt_o   = stall_cnt_r;

`ifdef PIPE_CTRL_JUMP_EN
  assign jump_o        = idex_r.jump;
  assign unused_bits_s = ^instr_i[10:0];
`else
  assign jump_o        = 1'b0;
  assign unused_bits_s = ^{instr_i[10:0], idex_r.jump};
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit plus hand sequences for reset and illegal.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        valid_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        stall_o, valid_o, regwrite_o, alusrc_o, regdst_o, branch_o;
  logic        memread_o, memwrite_o, memtoreg_o, jump_o, illegal_o;
  logic [2:0]  alu_op_o;
  logic [1:0]  branch_type_o;
  logic [4:0]  wr_reg_o;
  logic [15:0] stall_cnt_o;

  pipe_ctrl_unit dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i),
    .branch_taken_i(branch_taken_i), .stall_o(stall_o), .valid_o(valid_o),
    .regwrite_o(regwrite_o), .alusrc_o(alusrc_o), .regdst_o(regdst_o),
    .branch_o(branch_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .memtoreg_o(memtoreg_o), .jump_o(jump_o), .alu_op_o(alu_op_o),
    .branch_type_o(branch_type_o), .wr_reg_o(wr_reg_o), .illegal_o(illegal_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  // ctl bits: valid regwrite alusrc regdst branch memread memwrite memtoreg jump
  localparam logic [8:0] C_R    = 9'b110100000;
  localparam logic [8:0] C_BR   = 9'b100010000;
  localparam logic [8:0] C_IMM  = 9'b111000000;
  localparam logic [8:0] C_LW   = 9'b111001010;
  localparam logic [8:0] C_SW   = 9'b101000100;
  localparam logic [8:0] C_J    = 9'b100000001;
  localparam logic [8:0] C_JAL  = 9'b110000001;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        bt;
    logic        exp_stall;
    logic [19:0] exp_out;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [19:0] ex(input logic [8:0] ctl, input logic [2:0] alu,
                                     input logic [1:0] bt, input logic [4:0] wr, input logic ill);
    return {ctl, alu, bt, wr, ill};
  endfunction

  function automatic logic [19:0] act_out();
    return {valid_o, regwrite_o, alusrc_o, regdst_o, branch_o, memread_o, memwrite_o,
            memtoreg_o, jump_o, alu_op_o, branch_type_o, wr_reg_o, illegal_o};
  endfunction

  task automatic add(input logic [31:0] instr, input logic valid, input logic bt,
                     input logic st, input logic [19:0] eo, input logic [15:0] ec);
    vec_t v;
    v.instr = instr; v.valid = valid; v.bt = bt;
    v.exp_stall = st; v.exp_out = eo; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic bt);
    @(negedge clk);
    instr_i = instr; valid_i = valid; branch_taken_i = bt;
  endtask

  logic        ill_j;
  logic [19:0] e_j, e_jal;

  initial begin
    ill_j = !JEN;
    e_j   = JEN ? ex(C_J,   3'b000, 2'b11, 5'd0,  1'b0) : ex(9'd0, 3'b000, 2'b00, 5'd0, 1'b1);
    e_jal = JEN ? ex(C_JAL, 3'b000, 2'b11, 5'd31, 1'b0) : ex(9'd0, 3'b000, 2'b00, 5'd0, 1'b1);

    add(mk(6'd0, 5'd1, 5'd2, 5'd3),  1'b1, 1'b0, 1'b0, ex(C_R,   3'b010, 2'b11, 5'd3, 1'b0), 16'd0);
    add(mk(6'd4, 5'd1, 5'd2, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_BR,  3'b001, 2'b00, 5'd0, 1'b0), 16'd0);
    add(mk(6'd5, 5'd1, 5'd2, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_BR,  3'b001, 2'b11, 5'd0, 1'b0), 16'd0);
    add(mk(6'd7, 5'd1, 5'd2, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_BR,  3'b001, 2'b01, 5'd0, 1'b0), 16'd0);
    add(mk(6'd1, 5'd1, 5'd2, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_BR,  3'b001, 2'b10, 5'd0, 1'b0), 16'd0);
    add(mk(6'd8, 5'd1, 5'd7, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_IMM, 3'b000, 2'b11, 5'd7, 1'b0), 16'd0);
    add(mk(6'd10, 5'd1, 5'd4, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_IMM, 3'b100, 2'b11, 5'd4, 1'b0), 16'd0);
    add(mk(6'd35, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd5, 1'b0), 16'd0);
    add(mk(6'd43, 5'd2, 5'd6, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_SW,  3'b000, 2'b11, 5'd0, 1'b0), 16'd0);
    // lw $5 ; add $3,$5,$2 : one stall cycle with a bubble, then the add issues
    add(mk(6'd35, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd5, 1'b0), 16'd0);
    add(mk(6'd0, 5'd5, 5'd2, 5'd3),  1'b1, 1'b0, 1'b1, 20'd0, 16'd1);
    add(mk(6'd0, 5'd5, 5'd2, 5'd3),  1'b1, 1'b0, 1'b0, ex(C_R,   3'b010, 2'b11, 5'd3, 1'b0), 16'd1);
    // load into $0 never stalls
    add(mk(6'd35, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd0, 1'b0), 16'd1);
    add(mk(6'd0, 5'd0, 5'd2, 5'd3),  1'b1, 1'b0, 1'b0, ex(C_R,   3'b010, 2'b11, 5'd3, 1'b0), 16'd1);
    // flush beats stall
    add(mk(6'd35, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd5, 1'b0), 16'd1);
    add(mk(6'd0, 5'd5, 5'd2, 5'd3),  1'b1, 1'b1, 1'b0, 20'd0, 16'd1);
    add(mk(6'd0, 5'd1, 5'd2, 5'd3),  1'b0, 1'b0, 1'b0, 20'd0, 16'd1);
    // sw reads rt, so it stalls behind lw $6; addi does not read rt
    add(mk(6'd35, 5'd1, 5'd6, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd6, 1'b0), 16'd1);
    add(mk(6'd43, 5'd1, 5'd6, 5'd0), 1'b1, 1'b0, 1'b1, 20'd0, 16'd2);
    add(mk(6'd43, 5'd1, 5'd6, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_SW,  3'b000, 2'b11, 5'd0, 1'b0), 16'd2);
    add(mk(6'd35, 5'd1, 5'd6, 5'd0), 1'b1, 1'b0, 1'b0, ex(C_LW,  3'b000, 2'b11, 5'd6, 1'b0), 16'd2);
    add(mk(6'd8, 5'd1, 5'd6, 5'd0),  1'b1, 1'b0, 1'b0, ex(C_IMM, 3'b000, 2'b11, 5'd6, 1'b0), 16'd2);
    add(mk(6'd2, 5'd0, 5'd0, 5'd0),  1'b1, 1'b0, 1'b0, e_j, 16'd2);
    add(mk(6'd3, 5'd0, 5'd0, 5'd0),  1'b1, 1'b0, 1'b0, e_jal, 16'd2);
    add(mk(6'd63, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, ex(9'd0,  3'b000, 2'b00, 5'd0, 1'b1), 16'd2);
    add(mk(6'd0, 5'd1, 5'd2, 5'd3),  1'b1, 1'b0, 1'b0, ex(C_R,   3'b010, 2'b11, 5'd3, 1'b1), 16'd2);

    // reset state
    #12;
    check("reset_out", {12'd0, act_out()}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    check("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].valid, vecs[i].bt);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out", i), {12'd0, act_out()}, {12'd0, vecs[i].exp_out});
      check($sformatf("v%0d_cnt", i), {16'd0, stall_cnt_o}, {16'd0, vecs[i].exp_cnt});
    end
    if (ill_j) begin
      check("illegal_after_jump_disabled", {31'd0, illegal_o}, 32'd1);
    end

    // asynchronous reset mid-stall with lw $5 in ID/EX
    drive(mk(6'd35, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0);
    @(posedge clk);
    drive(mk(6'd0, 5'd5, 5'd2, 5'd3), 1'b1, 1'b0);
    #1;
    check("pre_reset_stall", {31'd0, stall_o}, 32'd1);
    check("pre_reset_memread", {31'd0, memread_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_out", {12'd0, act_out()}, 32'd0);
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    drive(32'd0, 1'b0, 1'b0);
    rst_i = 1'b1;

    // illegal opcode from a clean state, sticky through a legal instruction
    drive(mk(6'd63, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("illegal_out", {12'd0, act_out()}, {12'd0, ex(9'd0, 3'b000, 2'b00, 5'd0, 1'b1)});
    drive(mk(6'd8, 5'd1, 5'd7, 5'd0), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("illegal_sticky", {12'd0, act_out()}, {12'd0, ex(C_IMM, 3'b000, 2'b11, 5'd7, 1'b1)});
    drive(32'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    check("illegal_cleared", {31'd0, illegal_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    // jal from a clean state
    drive(mk(6'd3, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("jal_clean", {12'd0, act_out()},
          {12'd0, JEN ? ex(C_JAL, 3'b000, 2'b11, 5'd31, 1'b0) : ex(9'd0, 3'b000, 2'b00, 5'd0, 1'b1)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage MIPS-subset CPU: decodes the IF/ID instruction, registers the control bundle into the ID/EX pipeline register, detects load-use hazards, and inserts bubbles on stall or branch flush. It replaces the purely combinational decoder plus hand-built ID/EX control bits. It sits between the IF/ID register and the EX stage, driving the PC/IF-ID hold line.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- ALU_OP_W, 3, ALU_op width (minimum 3)
- CNT_W, 16, stall-counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- instr_i  in  32  IF/ID instruction
- valid_i  in  1  IF/ID slot holds a real instruction
- branch_taken_i  in  1  branch resolved taken in EX/MEM; flush
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- valid_o  out  1  ID/EX slot valid
- regwrite_o, alusrc_o, regdst_o, branch_o, memread_o, memwrite_o, memtoreg_o, jump_o  out  1 each  ID/EX control
- alu_op_o  out  ALU_OP_W  ID/EX ALU_op
- branch_type_o  out  2  ID/EX branch type
- wr_reg_o  out  REG_ADDR_W  ID/EX destination register
- illegal_o  out  1  sticky unknown-opcode flag
- stall_cnt_o  out  CNT_W  saturating load-use stall count

## Operation
- Opcodes (instr_i[31:26]): R-type 000000, beq 000100, bne 000101, bgt 000111, bge 000001, addi 001000, slti 001010, lw 100011, sw 101011.
- regdst = R; alusrc = addi|slti|lw|sw; regwrite = R|addi|slti|lw; branch = beq|bne|bgt|bge; memread = memtoreg = lw; memwrite = sw.
- alu_op: bit2 = slti, bit1 = R, bit0 = branch; upper bits (if ALU_OP_W>3) zero.
- branch_type: beq 00, bgt 01, bge 10, else 11 (bne and non-branches).
- wr_reg: rd (instr[15:11]) for R, else rt (instr[20:16]); forced 0 when regwrite=0.
- Unknown opcode with valid_i=1: decoded as bubble (all control 0, valid_o=0); illegal_o set, held until reset.
- Load-use: stall_o = valid_i & valid_o & memread_o & wr_reg_o≠0 & (wr_reg_o==rs | (wr_reg_o==rt & uses_rt)); uses_rt = R|beq|bne|bgt|bge|sw. Gated to 0 when branch_taken_i=1.
- Bubble: all control outputs, wr_reg_o, valid_o = 0.
- ID/EX load priority each edge: branch_taken_i → bubble; else stall_o → bubble; else valid_i=0 → bubble; else decoded instruction.
- stall_cnt_o increments on each cycle with stall_o=1, saturates at all-ones.

## Timing
- All outputs except stall_o are registered; decode-to-output latency 1 cycle.
- stall_o combinational from instr_i, valid_i, branch_taken_i and registered ID/EX state; no register-to-stall loop beyond that.
- Load-use stall lasts exactly one cycle: the inserted bubble clears memread_o, so the held instruction issues the next cycle.
- branch_taken_i and stall condition together: flush wins, stall_o=0, stall_cnt_o unchanged.
- Reset (asynchronous, any time incl. mid-stall): all outputs 0, illegal_o 0, stall_cnt_o 0; first decode at first rising edge after release.

## Configuration
- PIPE_CTRL_JUMP_EN defined: decodes j 000010 (jump_o=1) and jal 000011 (jump_o=1, regwrite_o=1, wr_reg_o=31); neither uses rt, neither sets illegal_o.
- Undefined: jump_o tied 0; 000010 and 000011 treated as unknown opcodes (bubble, illegal_o set).

## Test plan
- Reset: drive rst_i=0 mid-run with lw in ID/EX → all outputs 0 immediately, stall_cnt_o=0.
- Decode sweep: each opcode with valid_i=1 → next cycle matches table; slti gives alu_op_o=100, bgt gives branch_type_o=01, addi rt=7 gives wr_reg_o=7.
- Load-use: lw $5 then add $3,$5,$2 → stall_o=1 one cycle, bubble in ID/EX, add issues next cycle, stall_cnt_o=1; lw $0 then add $3,$0,$2 → no stall.
- Flush priority: lw $5 in ID/EX, add using $5 in ID, branch_taken_i=1 → stall_o=0, bubble loaded, stall_cnt_o unchanged.
- Illegal: opcode 111111 valid → valid_o=0, illegal_o=1 persisting through later legal instructions until reset.
- Macro: with PIPE_CTRL_JUMP_EN, jal → jump_o=1, regwrite_o=1, wr_reg_o=31; without, same opcode → illegal_o=1, jump_o=0.
